// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared encodings for the CPU memory responder
package cpu_mem_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
  typedef enum logic {SRC_IM, SRC_DM} src_e;
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: single-port word storage with synchronous write and read
module mem_word_array
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;
  // one shared port: write commits and read is captured on the same enabled edge
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= mem_q[addr_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: wait-stated memory responder for fetch and data strobes
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              im_r,
  input  logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_rdata,
  output logic              im_ready,
  input  logic              dm_cs,
  input  logic              dm_r,
  input  logic              dm_w,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              err
);
  localparam int AW = $clog2(DEPTH);
  state_e            st_q;
  logic [3:0]        cnt_q;
  op_e               op_q, op_d;
  src_e              src_q, src_d;
  logic              fault_q, fault_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d, mem_rdata;
  logic              im_ready_q, dm_ready_q, err_q, rd_ok_q;
  logic              idle, dm_req, cap, go_resp;
  logic [ADDR_W-1:0] a;
  // in IDLE the live request (data first) is used so a zero-wait access reaches the array this edge
  always_comb begin
    idle    = st_q == IDLE;
    dm_req  = dm_cs & (dm_r | dm_w);
    cap     = idle & (dm_req | im_r);
    a       = dm_req ? dm_addr : im_addr;
    src_d   = idle ? (dm_req ? SRC_DM : SRC_IM) : src_q;
    op_d    = idle ? ((dm_req & dm_w) ? OP_WR : OP_RD) : op_q;
    fault_d = idle ? ((|a[1:0]) | (|a[ADDR_W-1:AW+2]) | (dm_req & dm_r & dm_w)) : fault_q;
    idx_d   = idle ? a[AW+1:2] : idx_q;
    wdata_d = idle ? dm_wdata : wdata_q;
    go_resp = idle ? (cap & (WAIT_CYCLES == 0)) : (st_q == BUSY && cnt_q == 4'd0);
  end
  mem_word_array #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .en_i    (go_resp & ~fault_d),
    .we_i    (go_resp & ~fault_d & (op_d == OP_WR)),
    .addr_i  (idx_d),
    .wdata_i (wdata_d),
    .rdata_o (mem_rdata)
  );
  // request sequencing, wait-state counter and registered ready/err pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_RD;
      src_q      <= SRC_IM;
      fault_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      im_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      err_q      <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      st_q       <= go_resp ? RESP : (cap ? BUSY : (st_q == BUSY ? BUSY : IDLE));
      cnt_q      <= cap ? 4'(WAIT_CYCLES - 1) : (st_q == BUSY ? cnt_q - 4'd1 : cnt_q);
      op_q       <= op_d;
      src_q      <= src_d;
      fault_q    <= fault_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      im_ready_q <= go_resp & (src_d == SRC_IM);
      dm_ready_q <= go_resp & (src_d == SRC_DM);
      err_q      <= go_resp & fault_d;
      rd_ok_q    <= go_resp & ~fault_d & (op_d == OP_RD);
    end
  end
  assign im_ready = im_ready_q;
  assign dm_ready = dm_ready_q;
  assign err      = err_q;
  assign im_rdata = (im_ready_q & rd_ok_q) ? mem_rdata : '0;
  assign dm_rdata = (dm_ready_q & rd_ok_q) ? mem_rdata : '0;
endmodule
